afu_write_issuer: RTL and testbench
===================================

// Module: afu_write_issuer
// PURPOSE
//  Downstream drain stage of the AFU user block: pops 512-bit result cachelines from
//  the user output FIFO and issues them as write requests to consecutive cacheline
//  addresses from a programmed base. Tracks outstanding writes against a credit limit
//  and raises done once ctx_length write responses have returned.
// PARAMETERS
//  ADDR_WIDTH      32  cacheline address width (address units = 64-byte lines)
//  MAX_OUTSTANDING 32  max writes in flight (popped, response not yet received)
//  CNT_WIDTH       6   width of outstanding counter; must hold MAX_OUTSTANDING
// PORTS
//  clk            in   1           clock
//  reset          in   1           asynchronous reset, active low
//  start          in   1           1-cycle pulse: latch dst_base/ctx_length, begin job
//  dst_base       in   ADDR_WIDTH  first destination cacheline address
//  ctx_length     in   32          number of cachelines in job
//  fifo_dout      in   512         output FIFO read data, valid cycle after fifo_re
//  fifo_empty     in   1           output FIFO empty
//  fifo_re        out  1           output FIFO pop
//  wr_almost_full in   1           write channel backpressure; no new pop while high
//  wr_req_valid   out  1           write request strobe (1 cycle per line)
//  wr_req_addr    out  ADDR_WIDTH  write address
//  wr_req_data    out  512         write data
//  wr_rsp_valid   in   1           one write completion per cycle max
//  busy           out  1           job in progress (RUN or DRAIN)
//  done           out  1           job complete; held until next start
//  stall_cycles   out  32          perf counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; fifo_re, wr_req_valid, busy, done = 0;
//   wr_req_addr, wr_req_data, stall_cycles, all counters = 0.
//  FSM: IDLE -start-> RUN (ctx_length!=0) or DONE (ctx_length==0, done next cycle).
//   RUN -> DRAIN when pop_cnt==len; DRAIN -> DONE when rsp_cnt==len;
//   DONE -start-> RUN/DONE as from IDLE. start ignored in RUN/DRAIN.
//  Pop rule (RUN): fifo_re = !fifo_empty & !wr_almost_full & (outst<MAX_OUTSTANDING)
//   & (pop_cnt<len). Combinational from registered state and inputs.
//  Latency: fifo_re at cycle N -> wr_req_valid=1 at N+1 with wr_req_data=fifo_dout,
//   wr_req_addr=base+idx (idx=0..len-1, ADDR_WIDTH modulo wrap, no error).
//   Back-to-back pops give one request per cycle.
//  outst: +1 on fifo_re, -1 on wr_rsp_valid, unchanged if both same cycle; reserved at
//   pop so credit limit holds across the 1-cycle issue delay.
//  rsp_cnt counts wr_rsp_valid only while busy; responses in IDLE/DONE are ignored.
//  wr_almost_full rising in cycle N blocks pop in N; request already in flight from
//   N-1 still issues in N (channel slack absorbs it).
//  busy=1 in RUN/DRAIN; done=1 only in DONE; done drops the cycle after start.
//  Reset mid-job: all state cleared immediately, pending request dropped; no recovery.
// CONFIGURATION
//  AFU_WR_PERF_EN defined: stall_cycles clears on start, increments each RUN cycle with
//   !fifo_empty & (pop_cnt<len) & !fifo_re (blocked by almost_full or credits),
//   saturates at 32'hFFFFFFFF.
//  Not defined: stall_cycles tied to 0, no counter logic.
// TESTING
//  start, base=0x1000, len=4, FIFO preloaded 4 lines, rsp 2 cycles after each req ->
//   4 reqs on consecutive cycles at 0x1000..0x1003, data in FIFO order, done after 4th rsp.
//  len=0 start -> done=1 next cycle, no fifo_re, no wr_req_valid.
//  MAX_OUTSTANDING=2, len=8, responses withheld -> exactly 2 pops then stall;
//   each rsp releases one pop; done after 8 rsps.
//  wr_almost_full high cycles 3-7 of a 6-line job -> no fifo_re in 3-7, at most one
//   req issued in 3, all 6 lines at correct addresses.
//  base=0xFFFFFFFE, len=3 -> addrs 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
//  reset=0 mid-job (2 of 5 issued) -> all outputs 0 same cycle; new start runs clean;
//   with AFU_WR_PERF_EN, a 5-cycle almost_full block yields stall_cycles=5.

Source files
------------

// File: rtl/afu_write_issuer_if.sv
// FIFO-side and write-channel-side signals of the AFU write issuer.
// master = issuer, slave = FIFO + write channel.
interface afu_write_issuer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [511:0]          fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_re;
    logic                  wr_almost_full;
    logic                  wr_req_valid;
    logic [ADDR_WIDTH-1:0] wr_req_addr;
    logic [511:0]          wr_req_data;
    logic                  wr_rsp_valid;

    modport master (
        input  fifo_dout, fifo_empty,
        input  wr_almost_full, wr_rsp_valid,
        output fifo_re, wr_req_valid,
        output wr_req_addr, wr_req_data
    );

    modport slave (
        output fifo_dout, fifo_empty,
        output wr_almost_full, wr_rsp_valid,
        input  fifo_re, wr_req_valid,
        input  wr_req_addr, wr_req_data
    );
endinterface

// File: rtl/afu_write_issuer.sv
// Drains result lines from the user FIFO into credit-limited writes.
// Optional stall perf counter: define AFU_WR_PERF_EN.
module afu_write_issuer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 32,
    parameter int CNT_WIDTH       = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [31:0]           ctx_length,
    afu_write_issuer_if.master    wr,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           stall_cycles
);
    typedef enum logic [1:0] {
        IDLE, RUN, DRAIN, DONE
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           len;
    logic [31:0]           pop_cnt;
    logic [31:0]           rsp_cnt;
    logic [CNT_WIDTH-1:0]  outst;
    logic                  issue_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  launch;
    logic                  rsp_hit;
    logic                  can_pop;

    assign launch  = start & (state == IDLE || state == DONE);
    assign rsp_hit = wr.wr_rsp_valid & busy;
    // Credit is reserved at pop, so the issue cycle never overshoots.
    assign can_pop = (state == RUN) & !wr.fifo_empty
                   & !wr.wr_almost_full
                   & (outst < CNT_WIDTH'(MAX_OUTSTANDING))
                   & (pop_cnt < len);

    assign wr.fifo_re      = can_pop;
    assign wr.wr_req_valid = issue_q;
    assign wr.wr_req_addr  = addr_q;
    assign wr.wr_req_data  = issue_q ? wr.fifo_dout : '0;
    assign busy            = (state == RUN) || (state == DRAIN);
    assign done            = (state == DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start)
                    state_nxt = (ctx_length != 0) ? RUN : DONE;
            end
            RUN: begin
                if (pop_cnt == len)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (rsp_cnt == len)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base    <= '0;
            len     <= '0;
            pop_cnt <= '0;
            rsp_cnt <= '0;
            outst   <= '0;
            issue_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            issue_q <= can_pop;
            if (can_pop)
                addr_q <= base + ADDR_WIDTH'(pop_cnt);
            if (launch) begin
                base    <= dst_base;
                len     <= ctx_length;
                pop_cnt <= '0;
                rsp_cnt <= '0;
                outst   <= '0;
            end else begin
                if (can_pop)
                    pop_cnt <= pop_cnt + 32'd1;
                if (rsp_hit)
                    rsp_cnt <= rsp_cnt + 32'd1;
                unique case ({can_pop, rsp_hit})
                    2'b10: outst <= outst + CNT_WIDTH'(1);
                    2'b01: begin
                        if (outst != '0)
                            outst <= outst - CNT_WIDTH'(1);
                    end
                    default: outst <= outst;
                endcase
            end
        end
    end

`ifdef AFU_WR_PERF_EN
    logic [31:0] stall_q;
    logic        stalled;

    assign stalled = (state == RUN) & !wr.fifo_empty
                   & (pop_cnt < len) & !can_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_q <= '0;
        else if (launch)
            stall_q <= '0;
        else if (stalled && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_afu_write_issuer.sv
// Directed bench for afu_write_issuer with FIFO model and
// address/data scoreboard.
module tb_afu_write_issuer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dst_base = '0;
    logic [31:0] ctx_length = '0;
    logic        busy;
    logic        done;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    afu_write_issuer_if #(.ADDR_WIDTH(32)) bus ();

    afu_write_issuer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .dst_base     (dst_base),
        .ctx_length   (ctx_length),
        .wr           (bus.master),
        .busy         (busy),
        .done         (done),
        .stall_cycles (stall_cycles)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] data;
    } exp_t;

    exp_t sb[$];
    int   rq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   n_pop = 0;
    int   n_req = 0;
    int   n_rsp = 0;
    int   n_af_pop = 0;
    int   n_af_req = 0;

    logic [511:0] mem [0:127];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    logic [511:0] dout = '0;
    logic         af = 1'b0;
    logic         d1, d2;
    logic         rsp_auto = 1'b1;
    logic         man_rsp = 1'b0;

    assign bus.fifo_empty     = (rd_ptr == wr_ptr);
    assign bus.fifo_dout      = dout;
    assign bus.wr_almost_full = af;
    assign bus.wr_rsp_valid   = rsp_auto ? d2 : man_rsp;

    always @(posedge clk) cyc++;

    // Registered-read FIFO: data appears the cycle after the pop.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_re) begin
            dout   <= mem[rd_ptr % 128];
            rd_ptr <= rd_ptr + 1;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= bus.wr_req_valid;
            d2 <= d1;
        end
    end

    always @(negedge clk) begin
        if (bus.fifo_re) n_pop++;
        if (bus.fifo_re && af) n_af_pop++;
        if (bus.wr_rsp_valid) n_rsp++;
        if (bus.wr_req_valid) begin
            exp_t e;
            n_req++;
            rq.push_back(cyc);
            if (af) n_af_req++;
            n_chk++;
            if (sb.size() == 0) begin
                assert (1'b0) else
                    $error("FAIL sb_extra addr=%h exp=none",
                           bus.wr_req_addr);
            end else begin
                e = sb.pop_front();
                assert (bus.wr_req_addr === e.addr &&
                        bus.wr_req_data === e.data) n_pass++;
                else
                    $error("FAIL req addr=%h exp=%h data=%h exp=%h",
                           bus.wr_req_addr, e.addr,
                           bus.wr_req_data[63:0], e.data[63:0]);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_job(input logic [31:0] base, input int len);
        logic [511:0] line;
        for (int i = 0; i < len; i++) begin
            line = {16{$urandom}};
            mem[wr_ptr % 128] = line;
            wr_ptr++;
            sb.push_back('{base + i, line});
        end
        dst_base   = base;
        ctx_length = len;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (!done && k < bound) begin
            tick();
            k++;
        end
        chk(tag, done, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_re"}, bus.fifo_re, 0);
        chk({tag, "_valid"}, bus.wr_req_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_addr"}, bus.wr_req_addr, 0);
        chk({tag, "_data"}, bus.wr_req_data !== '0, 0);
        chk({tag, "_stall"}, stall_cycles, 0);
    endtask

    initial begin
        int p0, r0, s0, a0, b0, k;
        #1 reset = 1'b0;
        #1 chk_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();

        p0 = n_pop; r0 = n_req;
        load_job(32'h0, 0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        repeat (4) tick();
        chk("len0_pops", n_pop - p0, 0);
        chk("len0_reqs", n_req - r0, 0);

        p0 = n_pop; r0 = n_req; s0 = n_rsp;
        load_job(32'h1000, 4);
        chk("t1_busy", busy, 1);
        chk("t1_done_low", done, 0);
        wait_done("t1_done", 40);
        chk("t1_reqs", n_req - r0, 4);
        chk("t1_rsps", n_rsp - s0, 4);
        chk("t1_back2back", rq[r0 + 3] - rq[r0], 3);
        chk("t1_sb_empty", sb.size(), 0);

        rsp_auto = 1'b0;
        p0 = n_pop; r0 = n_req;
        load_job(32'h3000, 34);
        repeat (60) tick();
        chk("cr_pops_cap", n_pop - p0, 32);
        chk("cr_reqs_cap", n_req - r0, 32);
        chk("cr_busy", busy, 1);
        man_rsp = 1'b1;
        tick();
        man_rsp = 1'b0;
        repeat (4) tick();
        chk("cr_one_release", n_pop - p0, 33);
        man_rsp = 1'b1;
        repeat (33) tick();
        man_rsp = 1'b0;
        wait_done("cr_done", 20);
        chk("cr_reqs", n_req - r0, 34);
        chk("cr_sb_empty", sb.size(), 0);
        rsp_auto = 1'b1;

        r0 = n_req;
        load_job(32'h4000, 6);
        repeat (3) tick();
        af = 1'b1;
        a0 = n_af_pop; b0 = n_af_req;
        repeat (5) tick();
        af = 1'b0;
        chk("af_no_pop", n_af_pop - a0, 0);
        chk("af_one_req", n_af_req - b0, 1);
        wait_done("af_done", 40);
        chk("af_reqs", n_req - r0, 6);
        chk("af_sb_empty", sb.size(), 0);
`ifdef AFU_WR_PERF_EN
        chk("af_stall", stall_cycles, 5);
`else
        chk("af_stall", stall_cycles, 0);
`endif

        r0 = n_req;
        load_job(32'hFFFF_FFFE, 3);
        wait_done("wrap_done", 30);
        chk("wrap_reqs", n_req - r0, 3);
        chk("wrap_sb_empty", sb.size(), 0);

        r0 = n_req;
        load_job(32'h5000, 5);
        k = 0;
        while (n_req - r0 < 2 && k < 20) begin
            tick();
            k++;
        end
        chk("mid_two_issued", n_req - r0 >= 2, 1);
        reset = 1'b0;
        #1 chk_zero("mid_rst");
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        repeat (4) tick();
        r0 = n_req;
        load_job(32'h6000, 3);
        wait_done("post_rst_done", 30);
        chk("post_rst_reqs", n_req - r0, 3);
        chk("post_rst_sb", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
